avg_stream: RTL and testbench

Streaming block-averager that accepts one W-bit sample per cycle on a valid-qualified input. It packs every 2**N consecutive accepted samples into a frame and feeds that frame through the pipelined `sum` adder tree. For each complete frame it emits a single-cycle result carrying the frame sum and its average (sum / 2**N). It sits between a sample source such as an ADC or decimator front end and downstream DSP, and is the stream-side driver and consumer of the `sum` tree.

---
 rtl/avg_pkg.sv | 11 +
 rtl/avg_stream_sum.sv | 27 ++
 rtl/avg_stream.sv | 86 ++++++++
 tb/tb_avg_stream.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/avg_pkg.sv
// rtl/avg_pkg.sv - shared helpers for the averaging blocks
package avg_pkg;

    // Divide a frame sum by 2**n, optionally rounding half up.
    function automatic logic [31:0] avg_round(input logic [31:0] sum, input int n, input bit round);
        logic [31:0] bias;
        bias = round ? (32'd1 << (n - 1)) : 32'd0;
        return (sum + bias) >> n;
    endfunction

endpackage

// File: rtl/avg_stream_sum.sv
// rtl/avg_stream_sum.sv - pipelined adder tree, one register stage per level
module sum #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic                      clk,
    input  logic [2**N-1:0][W-1:0]    in,
    output logic [W+N-1:0]            out
);

    // Level l holds 2**(N-l) partial sums of width W+l; no reset, the data is qualified elsewhere.
    for (genvar l = 1; l <= N; l++) begin : lvl
        for (genvar j = 0; j < 2**(N-l); j++) begin : node
            logic [W+l-1:0] s_q;
            logic [W+l-1:0] s_d;
            if (l == 1) begin : leaf
                always_comb s_d = {1'b0, in[2*j]} + {1'b0, in[2*j+1]};
            end else begin : inner
                always_comb s_d = {1'b0, lvl[l-1].node[2*j].s_q} + {1'b0, lvl[l-1].node[2*j+1].s_q};
            end
            always_ff @(posedge clk) s_q <= s_d;
        end
    end

    assign out = lvl[N].node[0].s_q;

endmodule

// File: rtl/avg_stream.sv
// rtl/avg_stream.sv - streaming block averager feeding the sum tree
module avg_stream
    import avg_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int ROUND = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           in_val,
    input  logic [W-1:0]   in_dat,
    output logic           busy,
    output logic           out_val,
    output logic [W+N-1:0] out_sum,
    output logic [W-1:0]   out_avg
);

    localparam int            LEN  = 2**N;
    localparam logic [N-1:0]  LAST = N'(LEN - 1);

    typedef logic [LEN-1:0][W-1:0] frame_t;

    frame_t         buf_q, buf_d, frm_q, frm_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [N-1:0]   vp_q, vp_d;
    logic           out_val_q, out_val_d;
    logic           accept, close;
    logic [31:0]    avg_full;

    always_comb begin
        accept    = in_val && !clr;
        close     = accept && (idx_q == LAST);
        idx_d     = idx_q;
        buf_d     = buf_q;
        frm_d     = frm_q;
        if (clr) begin
            idx_d = '0;
        end else if (in_val) begin
            idx_d = idx_q + 1'b1;
        end
        if (accept) begin
            buf_d[idx_q] = in_dat;
        end
        // The closing sample bypasses the buffer so the frame launches on the same edge.
        if (close) begin
            frm_d       = buf_q;
            frm_d[LAST] = in_dat;
        end
        vp_d      = N'({vp_q, close});
        out_val_d = vp_q[N-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            frm_q     <= '0;
            vp_q      <= '0;
            out_val_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            frm_q     <= frm_d;
            vp_q      <= vp_d;
            out_val_q <= out_val_d;
        end
    end

    always_ff @(posedge clk) buf_q <= buf_d;

    sum #(.W(W), .N(N)) u_sum (
        .clk (clk),
        .in  (frm_q),
        .out (out_sum)
    );

    assign busy     = (idx_q != '0);
    assign out_val  = out_val_q;
    assign avg_full = avg_round(32'(out_sum), N, ROUND != 0);
    assign out_avg  = avg_full[W-1:0];

    always_comb begin
        if (out_val_q) assert (avg_full < (32'd1 << W));
    end

endmodule

// File: tb/tb_avg_stream.sv
// tb/tb_avg_stream.sv - randomized self-checking bench for avg_stream
module tb_avg_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_val;
    logic [7:0] in_dat;
    logic       busy0, busy1, out_val0, out_val1;
    logic [9:0] sum0, sum1;
    logic [7:0] avg0, avg1;

    always #5 clk = ~clk;

    avg_stream #(.W(8), .N(2), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_val(in_val), .in_dat(in_dat),
        .busy(busy0), .out_val(out_val0), .out_sum(sum0), .out_avg(avg0)
    );

    avg_stream #(.W(8), .N(2), .ROUND(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_val(in_val), .in_dat(in_dat),
        .busy(busy1), .out_val(out_val1), .out_sum(sum1), .out_avg(avg1)
    );

    typedef struct {
        int due;
        int s;
    } exp_t;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   cur[$];
    exp_t pend[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Called at a falling edge: check this cycle's outputs, drive inputs, advance the model.
    task automatic tick(input logic v, input logic [7:0] d, input logic c);
        logic exp_v;
        int   s;
        exp_v = (pend.size() > 0) && (pend[0].due == cyc);
        chk("out_val_r0", out_val0, exp_v);
        chk("out_val_r1", out_val1, exp_v);
        chk("busy_r0", busy0, cur.size() != 0);
        chk("busy_r1", busy1, cur.size() != 0);
        if (exp_v) begin
            s = pend[0].s;
            chk("sum_r0", sum0, s);
            chk("sum_r1", sum1, s);
            chk("avg_trunc", avg0, s / 4);
            chk("avg_round", avg1, (s + 2) / 4);
            void'(pend.pop_front());
        end
        in_val = v;
        in_dat = d;
        clr    = c;
        @(posedge clk);
        if (c) begin
            cur.delete();
        end else if (v) begin
            cur.push_back(int'(d));
            if (cur.size() == 4) begin
                s = 0;
                foreach (cur[i]) s += cur[i];
                pend.push_back('{cyc + 3, s});
                cur.delete();
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_val = 1'b0;
        clr    = 1'b0;
        rst    = 1'b1;
        cur.delete();
        pend.delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("rst_out_val", out_val0 | out_val1, 1'b0);
        chk("rst_busy", busy0 | busy1, 1'b0);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'd0, 1'b0);
    endtask

    task automatic frame(input int a, input int b, input int c, input int d);
        tick(1'b1, 8'(a), 1'b0);
        tick(1'b1, 8'(b), 1'b0);
        tick(1'b1, 8'(c), 1'b0);
        tick(1'b1, 8'(d), 1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        clr    = 1'b0;
        in_val = 1'b0;
        in_dat = 8'd0;
        @(negedge clk);
        do_reset();
        idle(3);

        frame(10, 20, 30, 40);
        idle(5);
        frame(255, 255, 255, 255);
        idle(5);
        frame(1, 2, 2, 2);
        idle(5);

        for (int i = 5; i <= 8; i++) begin
            idle($urandom_range(0, 3));
            tick(1'b1, 8'(i), 1'b0);
        end
        idle(5);

        tick(1'b1, 8'd50, 1'b0);
        tick(1'b1, 8'd60, 1'b0);
        tick(1'b0, 8'd0, 1'b1);
        frame(1, 2, 3, 4);
        idle(5);

        tick(1'b1, 8'd7, 1'b0);
        tick(1'b1, 8'd99, 1'b1);
        frame(11, 12, 13, 14);
        idle(5);

        frame(1, 2, 3, 4);
        frame(5, 6, 7, 8);
        idle(5);

        frame(1, 2, 3, 4);
        do_reset();
        idle(8);

        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 19) == 0);
        end
        idle(8);
        chk("drain", pend.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
